uart_rx_fifo_fill: RTL and testbench

- UART receiver (8N1, LSB first) that turns the serial rx pin into bytes and pushes each byte into the UART FIFO's write port.
- It is the stage directly upstream of the UART FIFO in the test design.
- It synchronises rx, validates start and stop bits, and pushes only good bytes.
- It reports framing errors, and reports overrun when the FIFO is full.

---
 rtl/uart_rx_fifo_fill.sv | 142 ++++++++++++++
 tb/tb_uart_rx_fifo_fill.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_fill.sv
// 8N1 UART receiver feeding a FIFO write port. A 2-flop synchroniser brings rx into the clock domain.
// Start and stop bits are checked, and only good bytes are pushed into the FIFO.
module uart_rx_fifo_fill #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       fifo_full,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_wr_data,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             sync1_reg;
  logic             rx_s;

  // Flops reset high so that reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync1_reg <= rx;
      rx_s      <= sync1_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= 8'h00;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (!rx_s) begin
            state_reg <= S_START;
            cnt_reg   <= '0;
            busy      <= 1'b1;
          end
        end

        // Recheck the start bit at its mid-point so short glitches are rejected.
        S_START: begin
          if (cnt_reg == CNT_HALF_LAST) begin
            cnt_reg <= '0;
            if (rx_s) begin
              state_reg <= S_IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg   <= S_DATA;
              bit_idx_reg <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        S_DATA: begin
          if (cnt_reg == CNT_BIT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
              state_reg <= S_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        S_STOP: begin
          if (cnt_reg == CNT_BIT_LAST) begin
            cnt_reg <= '0;
            if (rx_s) begin
              state_reg <= S_IDLE;
              busy      <= 1'b0;
              if (fifo_full) begin
                overrun <= 1'b1;
              end else begin
                fifo_wr_en   <= 1'b1;
                fifo_wr_data <= shift_reg;
              end
            end else begin
              frame_err <= 1'b1;
              state_reg <= S_BREAK;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        // A held-low line must go high again before a new start bit is accepted.
        S_BREAK: begin
          if (rx_s) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_fill.sv
// Directed bench for uart_rx_fifo_fill with CLKS_PER_BIT=16. The stop-bit edge N falls 154 cycles after edge0.
// Inputs are driven on falling edges, and outputs are sampled on falling edges.
module tb_uart_rx_fifo_fill;

  localparam int CPB = 16;
  localparam int N_OFS = 154;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       fifo_full;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int pass_count  = 0;
  int check_count = 0;

  int cyc = 0;
  int wr_count = 0;
  int fe_count = 0;
  int ov_count = 0;
  int excl_err = 0;
  int wr_cyc[$];
  logic [7:0] wr_dat[$];
  int last_fe_cyc = -1;
  int last_ov_cyc = -1;

  uart_rx_fifo_fill #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Event recorder: cyc at a falling edge equals the index of the preceding rising edge.
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_count++;
      wr_cyc.push_back(cyc);
      wr_dat.push_back(fifo_wr_data);
    end
    if (frame_err) begin
      fe_count++;
      last_fe_cyc = cyc;
    end
    if (overrun) begin
      ov_count++;
      last_ov_cyc = cyc;
    end
    if ((32'(fifo_wr_en) + 32'(frame_err) + 32'(overrun)) > 1) excl_err++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", pass_count, check_count + 1);
    $fatal(1, "timeout");
  end

  // Must be called at a falling edge; returns at a falling edge after the stop bit.
  task automatic send_frame(input logic [7:0] data, input logic stop, output int e0);
    rx = 1'b0;
    e0 = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx = 1'b1;
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check_count++;
    if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); else pass_count++;
    check_count++;
    if (fifo_wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", fifo_wr_data); else pass_count++;
    check_count++;
    if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_count++;
    check_count++;
    if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_count++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_count++;
    if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_count++;
  endtask

  task automatic test_single_byte;
    int e0;
    int base_wr;
    int base_fe;
    int base_ov;
    base_wr = wr_count;
    base_fe = fe_count;
    base_ov = ov_count;
    send_frame(8'hA5, 1'b1, e0);
    repeat (4) @(negedge clk);
    check_count++;
    if (wr_count - base_wr !== 1) $display("FAIL single_wr_count: got %0d want 1", wr_count - base_wr); else pass_count++;
    if (wr_count - base_wr >= 1) begin
      check_count++;
      if (wr_cyc[base_wr] !== e0 + N_OFS)
        $display("FAIL single_wr_time: got edge %0d want %0d", wr_cyc[base_wr] - e0, N_OFS);
      else pass_count++;
      check_count++;
      if (wr_dat[base_wr] !== 8'hA5) $display("FAIL single_wr_data: got %h want a5", wr_dat[base_wr]); else pass_count++;
    end
    check_count++;
    if ((fe_count - base_fe) + (ov_count - base_ov) !== 0)
      $display("FAIL single_no_err: got fe=%0d ov=%0d want 0 0", fe_count - base_fe, ov_count - base_ov);
    else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else pass_count++;
    check_count++;
    if (fifo_wr_data !== 8'hA5) $display("FAIL single_data_hold: got %h want a5", fifo_wr_data); else pass_count++;
  endtask

  task automatic test_back_to_back;
    int e0a;
    int e0b;
    int base_wr;
    base_wr = wr_count;
    send_frame(8'h00, 1'b1, e0a);
    send_frame(8'hFF, 1'b1, e0b);
    repeat (4) @(negedge clk);
    check_count++;
    if (wr_count - base_wr !== 2) $display("FAIL b2b_wr_count: got %0d want 2", wr_count - base_wr); else pass_count++;
    if (wr_count - base_wr >= 2) begin
      check_count++;
      if (wr_cyc[base_wr] !== e0a + N_OFS)
        $display("FAIL b2b_first_time: got edge %0d want %0d", wr_cyc[base_wr] - e0a, N_OFS);
      else pass_count++;
      check_count++;
      if (wr_cyc[base_wr + 1] - wr_cyc[base_wr] !== 160)
        $display("FAIL b2b_spacing: got %0d want 160", wr_cyc[base_wr + 1] - wr_cyc[base_wr]);
      else pass_count++;
      check_count++;
      if (wr_dat[base_wr] !== 8'h00) $display("FAIL b2b_data0: got %h want 00", wr_dat[base_wr]); else pass_count++;
      check_count++;
      if (wr_dat[base_wr + 1] !== 8'hFF) $display("FAIL b2b_data1: got %h want ff", wr_dat[base_wr + 1]); else pass_count++;
    end
  endtask

  task automatic test_glitch;
    int e0;
    int base_wr;
    base_wr = wr_count;
    rx = 1'b0;
    e0 = cyc + 1;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    check_count++;
    if (busy !== 1'b1) $display("FAIL glitch_busy_mid: got %b want 1", busy); else pass_count++;
    repeat (8) @(negedge clk);
    check_count++;
    if (busy !== 1'b0) $display("FAIL glitch_busy_edge11: got %b want 0 at edge %0d", busy, cyc - e0); else pass_count++;
    repeat (20) @(negedge clk);
    check_count++;
    if (wr_count !== base_wr) $display("FAIL glitch_no_write: got %0d writes want 0", wr_count - base_wr); else pass_count++;
    send_frame(8'h3C, 1'b1, e0);
    repeat (4) @(negedge clk);
    check_count++;
    if (wr_count - base_wr !== 1) $display("FAIL glitch_next_count: got %0d want 1", wr_count - base_wr); else pass_count++;
    if (wr_count - base_wr >= 1) begin
      check_count++;
      if (wr_dat[base_wr] !== 8'h3C) $display("FAIL glitch_next_data: got %h want 3c", wr_dat[base_wr]); else pass_count++;
    end
  endtask

  task automatic test_framing;
    int e0;
    int base_wr;
    int base_fe;
    base_wr = wr_count;
    base_fe = fe_count;
    send_frame(8'h5A, 1'b0, e0);
    repeat (40) @(negedge clk);
    check_count++;
    if (fe_count - base_fe !== 1) $display("FAIL frame_err_count: got %0d want 1", fe_count - base_fe); else pass_count++;
    check_count++;
    if (last_fe_cyc !== e0 + N_OFS) $display("FAIL frame_err_time: got edge %0d want %0d", last_fe_cyc - e0, N_OFS); else pass_count++;
    check_count++;
    if (wr_count !== base_wr) $display("FAIL frame_no_write: got %0d writes want 0", wr_count - base_wr); else pass_count++;
    check_count++;
    if (busy !== 1'b1) $display("FAIL frame_busy_break: got %b want 1", busy); else pass_count++;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check_count++;
    if (busy !== 1'b0) $display("FAIL frame_busy_release: got %b want 0", busy); else pass_count++;
    repeat (10) @(negedge clk);
    send_frame(8'h81, 1'b1, e0);
    repeat (4) @(negedge clk);
    check_count++;
    if (wr_count - base_wr !== 1) $display("FAIL frame_next_count: got %0d want 1", wr_count - base_wr); else pass_count++;
    if (wr_count - base_wr >= 1) begin
      check_count++;
      if (wr_dat[base_wr] !== 8'h81) $display("FAIL frame_next_data: got %h want 81", wr_dat[base_wr]); else pass_count++;
    end
  endtask

  task automatic test_overrun;
    int e0;
    int base_wr;
    int base_ov;
    base_wr = wr_count;
    base_ov = ov_count;
    fifo_full = 1'b1;
    send_frame(8'h42, 1'b1, e0);
    repeat (4) @(negedge clk);
    fifo_full = 1'b0;
    check_count++;
    if (ov_count - base_ov !== 1) $display("FAIL overrun_count: got %0d want 1", ov_count - base_ov); else pass_count++;
    check_count++;
    if (last_ov_cyc !== e0 + N_OFS) $display("FAIL overrun_time: got edge %0d want %0d", last_ov_cyc - e0, N_OFS); else pass_count++;
    check_count++;
    if (wr_count !== base_wr) $display("FAIL overrun_no_write: got %0d writes want 0", wr_count - base_wr); else pass_count++;
    check_count++;
    if (fifo_wr_data !== 8'h81) $display("FAIL overrun_data_hold: got %h want 81", fifo_wr_data); else pass_count++;
  endtask

  task automatic test_reset_mid_frame;
    int e0;
    int base_wr;
    int base_fe;
    logic [7:0] pat;
    pat = 8'hC3;
    base_wr = wr_count;
    base_fe = fe_count;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = pat[i];
      repeat (CPB) @(negedge clk);
    end
    rx = pat[3];
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_count++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_count++;
    check_count++;
    if (fifo_wr_data !== 8'h00) $display("FAIL rstmid_wr_data: got %h want 00", fifo_wr_data); else pass_count++;
    check_count++;
    if ({fifo_wr_en, frame_err, overrun} !== 3'b000)
      $display("FAIL rstmid_pulses: got %b want 000", {fifo_wr_en, frame_err, overrun});
    else pass_count++;
    for (int i = 0; i < 6; i++) begin
      rx = ~rx;
      @(negedge clk);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check_count++;
    if ((wr_count !== base_wr) || (fe_count !== base_fe))
      $display("FAIL rstmid_no_event: got wr=%0d fe=%0d want 0 0", wr_count - base_wr, fe_count - base_fe);
    else pass_count++;
    send_frame(8'hC3, 1'b1, e0);
    repeat (4) @(negedge clk);
    check_count++;
    if (wr_count - base_wr !== 1) $display("FAIL rstmid_next_count: got %0d want 1", wr_count - base_wr); else pass_count++;
    if (wr_count - base_wr >= 1) begin
      check_count++;
      if (wr_dat[base_wr] !== 8'hC3) $display("FAIL rstmid_next_data: got %h want c3", wr_dat[base_wr]); else pass_count++;
      check_count++;
      if (wr_cyc[base_wr] !== e0 + N_OFS)
        $display("FAIL rstmid_next_time: got edge %0d want %0d", wr_cyc[base_wr] - e0, N_OFS);
      else pass_count++;
    end
  endtask

  task automatic test_exclusive;
    check_count++;
    if (excl_err !== 0) $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", excl_err); else pass_count++;
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    fifo_full = 1'b0;
    @(negedge clk);
    test_reset;
    test_single_byte;
    repeat (10) @(negedge clk);
    test_back_to_back;
    repeat (10) @(negedge clk);
    test_glitch;
    repeat (10) @(negedge clk);
    test_framing;
    repeat (10) @(negedge clk);
    test_overrun;
    repeat (10) @(negedge clk);
    test_reset_mid_frame;
    test_exclusive;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
